// File: rtl/hazard_sequencer.sv
// Hazard sequencer for a 5-stage MIPS pipeline: load-use stalls, redirect flushes,
// and a drain-then-halt sequence. Saturating stall/flush event counters.
module hazard_sequencer #(
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             branch_taken,
    input  logic             jump_taken,
    input  logic             halt_req,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             flush_exmem,
    output logic             flush_memwb,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_RELOAD = DW'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } state_e;

    state_e           state_q, state_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    logic load_use;
    logic redirect;

    assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    assign redirect = jump_taken || branch_taken;

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        flush_exmem = 1'b0;
        flush_memwb = 1'b0;
        halted      = 1'b0;
        state_d     = state_q;
        drain_d     = drain_q;
        stall_d     = stall_q;
        flush_d     = flush_q;

        if (rst) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            flush_ifid  = 1'b1;
            flush_idex  = 1'b1;
            flush_exmem = 1'b1;
            flush_memwb = 1'b1;
        end else begin
            // Redirect outranks every state-specific action; jump also kills MEM/WB.
            if (redirect) begin
                flush_ifid  = 1'b1;
                flush_idex  = 1'b1;
                flush_exmem = 1'b1;
                flush_memwb = jump_taken;
                if (flush_q != '1) begin
                    flush_d = flush_q + CNT_W'(1);
                end
            end

            unique case (state_q)
                RUN: begin
                    if (!redirect) begin
                        if (load_use) begin
                            pc_we      = 1'b0;
                            ifid_we    = 1'b0;
                            flush_idex = 1'b1;
                            if (stall_q != '1) begin
                                stall_d = stall_q + CNT_W'(1);
                            end
                        end else if (halt_req) begin
                            state_d = DRAIN;
                            drain_d = DRAIN_RELOAD;
                        end
                    end
                end

                DRAIN: begin
                    if (redirect) begin
                        drain_d = DRAIN_RELOAD;
                    end else if (load_use) begin
                        pc_we      = 1'b0;
                        ifid_we    = 1'b0;
                        flush_idex = 1'b1;
                        if (stall_q != '1) begin
                            stall_d = stall_q + CNT_W'(1);
                        end
                    end else begin
                        // PC stays on the first discarded fetch so resume refetches it.
                        pc_we      = 1'b0;
                        flush_ifid = 1'b1;
                        if (drain_q == '0) begin
                            state_d = HALTED;
                        end else begin
                            drain_d = drain_q - DW'(1);
                        end
                    end
                end

                HALTED: begin
                    halted = 1'b1;
                    if (!redirect) begin
                        pc_we      = 1'b0;
                        flush_ifid = 1'b1;
                    end
                    if (!halt_req) begin
                        state_d = RUN;
                    end
                end

                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            drain_q <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed table-driven bench for hazard_sequencer (DRAIN_CYCLES=4, CNT_W=4 so
// counter saturation is reachable in a few dozen cycles).
module tb_hazard_sequencer;

    localparam int unsigned CW = 4;

    // Output bundle: {pc_we, ifid_we, flush_ifid, flush_idex, flush_exmem, flush_memwb, halted}
    localparam logic [6:0] O_DEF = 7'b1100000;
    localparam logic [6:0] O_STL = 7'b0001000;
    localparam logic [6:0] O_BR  = 7'b1111100;
    localparam logic [6:0] O_JP  = 7'b1111110;
    localparam logic [6:0] O_DRN = 7'b0110000;
    localparam logic [6:0] O_HLT = 7'b0110001;
    localparam logic [6:0] O_HBR = 7'b1111101;
    localparam logic [6:0] O_RST = 7'b0011110;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    id_rs, id_rt, ex_rt;
    logic          id_uses_rt, ex_mem_read, branch_taken, jump_taken, halt_req;
    logic          pc_we, ifid_we, flush_ifid, flush_idex, flush_exmem, flush_memwb, halted;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       ur;
        logic       mr;
        logic [4:0] ert;
        logic       br;
        logic       jp;
        logic       hr;
        logic [6:0] exp_o;
        int         exp_sc;
        int         exp_fc;
    } vec_t;

    vec_t vecs[30];

    always #5 clk = ~clk;

    hazard_sequencer #(.DRAIN_CYCLES(4), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .ex_mem_read  (ex_mem_read),
        .ex_rt        (ex_rt),
        .branch_taken (branch_taken),
        .jump_taken   (jump_taken),
        .halt_req     (halt_req),
        .pc_we        (pc_we),
        .ifid_we      (ifid_we),
        .flush_ifid   (flush_ifid),
        .flush_idex   (flush_idex),
        .flush_exmem  (flush_exmem),
        .flush_memwb  (flush_memwb),
        .halted       (halted),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                                input logic mr, input logic [4:0] ert, input logic br,
                                input logic jp, input logic hr, input logic [6:0] o,
                                input int sc, input int fc);
        vec_t v;
        v.rs = rs; v.rt = rt; v.ur = ur; v.mr = mr; v.ert = ert;
        v.br = br; v.jp = jp; v.hr = hr; v.exp_o = o; v.exp_sc = sc; v.exp_fc = fc;
        return v;
    endfunction

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                         input logic mr, input logic [4:0] ert, input logic br,
                         input logic jp, input logic hr);
        id_rs = rs; id_rt = rt; id_uses_rt = ur; ex_mem_read = mr;
        ex_rt = ert; branch_taken = br; jump_taken = jp; halt_req = hr;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] outs();
        return {pc_we, ifid_we, flush_ifid, flush_idex, flush_exmem, flush_memwb, halted};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // rs, rt, ur, mr, ert, br, jp, hr, outputs, stall_cnt, flush_cnt (before the edge)
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, O_DEF, 0, 0);
        vecs[1]  = mk(2, 0, 0, 1, 2, 0, 0, 0, O_STL, 0, 0);
        vecs[2]  = mk(2, 0, 0, 0, 2, 0, 0, 0, O_DEF, 1, 0);
        vecs[3]  = mk(0, 0, 0, 1, 0, 0, 0, 0, O_DEF, 1, 0);
        vecs[4]  = mk(5, 3, 0, 1, 3, 0, 0, 0, O_DEF, 1, 0);
        vecs[5]  = mk(5, 3, 1, 1, 3, 0, 0, 0, O_STL, 1, 0);
        vecs[6]  = mk(2, 0, 0, 1, 2, 1, 0, 0, O_BR,  2, 0);
        vecs[7]  = mk(0, 0, 0, 0, 0, 1, 1, 0, O_JP,  2, 1);
        vecs[8]  = mk(0, 0, 0, 0, 0, 0, 1, 0, O_JP,  2, 2);
        vecs[9]  = mk(2, 0, 0, 1, 2, 0, 0, 1, O_STL, 2, 3);
        vecs[10] = mk(0, 0, 0, 0, 0, 1, 0, 1, O_BR,  3, 3);
        vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 1, O_DEF, 3, 4);
        vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 1, O_DRN, 3, 4);
        vecs[13] = mk(2, 0, 0, 1, 2, 0, 0, 0, O_STL, 3, 4);
        vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 1, O_DRN, 4, 4);
        vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 1, O_DRN, 4, 4);
        vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 1, O_DRN, 4, 4);
        vecs[17] = mk(0, 0, 0, 0, 0, 0, 0, 1, O_HLT, 4, 4);
        vecs[18] = mk(0, 0, 0, 0, 0, 1, 0, 1, O_HBR, 4, 4);
        vecs[19] = mk(0, 0, 0, 0, 0, 0, 0, 1, O_HLT, 4, 5);
        vecs[20] = mk(0, 0, 0, 0, 0, 0, 0, 0, O_HLT, 4, 5);
        vecs[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, O_DEF, 4, 5);
        vecs[22] = mk(0, 0, 0, 0, 0, 0, 0, 1, O_DEF, 4, 5);
        vecs[23] = mk(0, 0, 0, 0, 0, 0, 0, 1, O_DRN, 4, 5);
        vecs[24] = mk(0, 0, 0, 0, 0, 0, 1, 1, O_JP,  4, 5);
        vecs[25] = mk(0, 0, 0, 0, 0, 0, 0, 1, O_DRN, 4, 6);
        vecs[26] = mk(0, 0, 0, 0, 0, 0, 0, 1, O_DRN, 4, 6);
        vecs[27] = mk(0, 0, 0, 0, 0, 0, 0, 1, O_DRN, 4, 6);
        vecs[28] = mk(0, 0, 0, 0, 0, 0, 0, 1, O_DRN, 4, 6);
        vecs[29] = mk(0, 0, 0, 0, 0, 0, 0, 1, O_HLT, 4, 6);

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("reset_outputs", 32'(outs()), 32'(O_RST));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_outputs", 32'(outs()), 32'(O_DEF));
        check("post_reset_stall_cnt", 32'(stall_cnt), 0);
        check("post_reset_flush_cnt", 32'(flush_cnt), 0);
        @(posedge clk); #1;

        for (int i = 0; i < 30; i++) begin
            drive(vecs[i].rs, vecs[i].rt, vecs[i].ur, vecs[i].mr, vecs[i].ert,
                  vecs[i].br, vecs[i].jp, vecs[i].hr);
            @(negedge clk);
            check($sformatf("vec%0d_outputs", i), 32'(outs()), 32'(vecs[i].exp_o));
            check($sformatf("vec%0d_stall_cnt", i), 32'(stall_cnt), 32'(vecs[i].exp_sc));
            check($sformatf("vec%0d_flush_cnt", i), 32'(flush_cnt), 32'(vecs[i].exp_fc));
            @(posedge clk); #1;
        end

        // Resume from HALTED, then reset in the middle of a drain.
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("halted_release_cycle", 32'(outs()), 32'(O_HLT));
        @(posedge clk); #1;
        @(negedge clk);
        check("resume_run", 32'(outs()), 32'(O_DEF));
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("drain_before_reset", 32'(outs()), 32'(O_DRN));
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("reset_in_drain", 32'(outs()), 32'(O_RST));
        @(posedge clk); #1;
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("after_drain_reset_outputs", 32'(outs()), 32'(O_DEF));
        check("after_drain_reset_stall_cnt", 32'(stall_cnt), 0);
        check("after_drain_reset_flush_cnt", 32'(flush_cnt), 0);
        @(posedge clk); #1;

        // Saturation: 18 stall cycles and 17 flush cycles into 4-bit counters.
        drive(7, 0, 0, 1, 7, 0, 0, 0);
        for (int i = 0; i < 18; i++) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("stall_cnt_saturated", 32'(stall_cnt), 32'hF);
        check("flush_cnt_idle", 32'(flush_cnt), 0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 17; i++) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("flush_cnt_saturated", 32'(flush_cnt), 32'hF);
        check("stall_cnt_held", 32'(stall_cnt), 32'hF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_sequencer.md
HAZARD_SEQUENCER -- requirements
Module: hazard_sequencer

Interface
REQ-001 Parameter DRAIN_CYCLES, default 4: non-stall cycles spent emptying the pipeline before HALTED.
REQ-002 Parameter CNT_W, default 16: width of the event counters.
REQ-003 clk  in  1  single clock; every register updates on its rising edge.
REQ-004 rst  in  1  reset; synchronous and active-high.
REQ-005 id_rs  in  5  rs field of the instruction in ID (IF/ID bits 25:21).
REQ-006 id_rt  in  5  rt field of the instruction in ID (IF/ID bits 20:16).
REQ-007 id_uses_rt  in  1  ID instruction reads rt as a source (R-type, beq, sw).
REQ-008 ex_mem_read  in  1  MemRead of the instruction in EX (ID/EX output).
REQ-009 ex_rt  in  5  rt destination of the instruction in EX.
REQ-010 branch_taken  in  1  Branch AND Zero at MEM (PC redirect from a branch).
REQ-011 jump_taken  in  1  Jump flag at WB (PC redirect from a jump).
REQ-012 halt_req  in  1  level request to drain and halt the pipeline.
REQ-013 pc_we  out  1  PC write enable.
REQ-014 ifid_we  out  1  IF/ID buffer write enable.
REQ-015 flush_ifid / flush_idex / flush_exmem / flush_memwb  out  1 each  load a NOP/zero-control bubble into that buffer at the next edge.
REQ-016 halted  out  1  pipeline drained and frozen at the fetch stage.
REQ-017 stall_cnt  out  CNT_W  count of load-use stall cycles.
REQ-018 flush_cnt  out  CNT_W  count of redirect cycles.

Function
REQ-019 load_use SHALL be defined as ex_mem_read AND ex_rt!=0 AND (ex_rt==id_rs OR (id_uses_rt AND ex_rt==id_rt)).
REQ-020 The FSM SHALL have three states: RUN, DRAIN and HALTED. The state, a drain counter and both event counters are registered. All other outputs are combinational from the state and the current inputs.
REQ-021 Default outputs SHALL be pc_we=1, ifid_we=1 and all flush_*=0.
REQ-022 jump_taken=1, in any state, SHALL assert all four flush_* with pc_we=1 and ifid_we=1.
REQ-023 branch_taken=1 with jump_taken=0 SHALL assert flush_ifid, flush_idex and flush_exmem, with flush_memwb=0.
REQ-024 When both redirects are asserted, the jump rule (REQ-022) SHALL apply and flush_cnt SHALL increment by 1 only.
REQ-025 A redirect SHALL override load_use in the same cycle: no stall, and stall_cnt SHALL NOT increment.
REQ-026 load_use without a redirect SHALL give pc_we=0, ifid_we=0, flush_idex=1 and all other flushes 0, and stall_cnt SHALL increment.
REQ-027 The stall SHALL last exactly as long as load_use holds, normally 1 cycle, because the injected bubble clears ex_mem_read.
REQ-028 RUN->DRAIN SHALL occur at the edge when halt_req=1, no redirect and no load_use. The drain counter SHALL load DRAIN_CYCLES-1.
REQ-029 In RUN, halt_req coinciding with a redirect or load_use SHALL be deferred; it is a level and is re-evaluated every cycle.
REQ-030 In DRAIN, non-stall, non-redirect cycles SHALL give pc_we=0, ifid_we=1, flush_ifid=1, and the counter SHALL decrement.
REQ-031 In DRAIN, load_use SHALL apply REQ-026 and the counter SHALL hold.
REQ-032 In DRAIN, a redirect SHALL apply REQ-022/023 and the counter SHALL reload DRAIN_CYCLES-1.
REQ-033 DRAIN->HALTED SHALL occur at the edge where the counter equals 0 on a decrementing cycle. halt_req is ignored while in DRAIN.
REQ-034 In HALTED: halted=1, pc_we=0, ifid_we=1, flush_ifid=1. Redirects still apply REQ-022/023 (outputs only).
REQ-035 HALTED->RUN SHALL occur at the edge where halt_req=0. halted falls in the first RUN cycle.
REQ-036 The held PC in DRAIN/HALTED SHALL be the address of the first discarded fetch, so resume refetches it with no instruction lost.
REQ-037 stall_cnt and flush_cnt SHALL saturate at all-ones and never wrap.

Reset
REQ-038 While rst=1, outputs SHALL be pc_we=0, ifid_we=0, all flush_*=1 and halted=0.
REQ-039 At an edge with rst=1: state=RUN, drain counter=0, stall_cnt=0, flush_cnt=0.
REQ-040 Reset SHALL abort DRAIN or HALTED immediately, with no completion of drain.
REQ-041 The first cycle after rst falls SHALL show the default RUN outputs.

Verification
REQ-042 lw $2 in EX (ex_mem_read=1, ex_rt=2) with id_rs=2 -> exactly 1 cycle of pc_we=0, ifid_we=0, flush_idex=1; then stall_cnt=1.
REQ-043 ex_rt=0 with ex_mem_read=1 and id_rs=0, and separately id_rt match with id_uses_rt=0 -> no stall; stall_cnt unchanged.
REQ-044 branch_taken and load_use in the same cycle -> flush_ifid, flush_idex and flush_exmem =1, pc_we=1, flush_cnt +1, stall_cnt +0. jump_taken plus branch_taken -> all four flushes, flush_cnt +1.
REQ-045 halt_req=1 from RUN with DRAIN_CYCLES=4 and one load_use injected mid-drain -> halted rises after exactly 5 cycles in DRAIN. Dropping halt_req -> RUN next cycle with pc_we=1.
REQ-046 Preload both counters near all-ones, then drive repeated stalls and flushes -> each counter holds at all-ones. rst=1 during DRAIN -> next cycle shows RUN, counters 0, halted=0.
